// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes and datapath selects.
// The UIMM state exists only when UTYPE_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
`ifdef UTYPE_EN
        S_UIMM,
`endif
        S_ILLEGAL
    } state_t;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_I = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
`ifdef UTYPE_EN
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
`endif

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Only beq/bne are implemented
    function automatic logic branch_funct_ok(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps the operation class and funct fields to ALUControl,
// and flags funct3 values the ALU does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_funct_illegal
);

    assign o_funct_illegal = !((i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                               (i_funct3 == 3'b110) || (i_funct3 == 3'b111));

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // op[5] separates R-type from I-type so addi never becomes sub
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute over a shared datapath.
// Define UTYPE_EN to add lui/auipc support via the UIMM state.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    state_t     r_state;
    logic [1:0] w_aluop;
    logic       w_funct_illegal;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    alu_decoder u_alu_decoder (
        .i_aluop         (w_aluop),
        .i_funct3        (funct3),
        .i_funct7b5      (funct7b5),
        .i_op5           (op[5]),
        .o_alu_control   (ALUControl),
        .o_funct_illegal (w_funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:  r_state <= w_funct_illegal ? S_ILLEGAL : S_EXECR;
                        OP_ITYPE:  r_state <= w_funct_illegal ? S_ILLEGAL : S_EXECI;
                        OP_BRANCH: r_state <= branch_funct_ok(funct3) ? S_BRANCH : S_ILLEGAL;
                        OP_JAL:    r_state <= S_JAL;
`ifdef UTYPE_EN
                        OP_LUI, OP_AUIPC: r_state <= S_UIMM;
`endif
                        default:   r_state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
`ifdef UTYPE_EN
                S_UIMM:     r_state <= S_ALUWB;
`endif
                S_ILLEGAL:  r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_aluop     = ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                w_pc_write = mem_ready;
                w_ir_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_RDATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                w_aluop = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                w_aluop    = ALUOP_SUB;
                w_pc_write = zero ^ funct3[0];
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
`ifdef UTYPE_EN
            S_UIMM: begin
                // lui adds the immediate to zero, auipc to the instruction's PC
                ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
`endif
            S_ILLEGAL:  w_illegal = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite  = w_pc_write  & ~reset;
    assign IRWrite  = w_ir_write  & ~reset;
    assign MemWrite = w_mem_write & ~reset;
    assign RegWrite = w_reg_write & ~reset;
    assign illegal  = w_illegal   & ~reset;

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = IMM_I;
            OP_STORE:          ImmSrc = IMM_S;
            OP_BRANCH:         ImmSrc = IMM_B;
            OP_JAL:            ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
            default:           ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle RISC-V control unit sequencing the shared datapath (PC, single unified memory port, instruction register, register file, ALU, immediate extender). A Moore state machine steps each instruction through fetch, decode and execute phases, driving mux selects, write strobes, the ALU operation and the extender's immediate-format select. Memory phases stall on a ready handshake. Unsupported encodings raise a one-cycle illegal flag and resume fetch.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction[6:0] from IR
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC load strobe
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- IRWrite  out  1  IR/OldPC load strobe
- MemWrite  out  1  memory write request
- RegWrite  out  1  register-file write strobe
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1, 11 zero
- ALUSrcB  out  2  00 rd2, 01 ImmExt, 10 constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  3  000 U, 001 S, 010 B, 011 J, 100 I (extender treats ImmSrc[2]=1 as I-type)
- illegal  out  1  one-cycle pulse on unsupported instruction

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, UIMM, ILLEGAL.
- FETCH: AdrSrc0, A00, B10, add, ResultSrc10; IRWrite=PCWrite=mem_ready; hold until mem_ready, then DECODE.
- DECODE: A01, B01, add (branch/jump target into ALUOut). Next: lw(0000011)/sw(0100011)→MEMADR; R(0110011)→EXECR; I-ALU(0010011)→EXECI; branch(1100011)→BRANCH; jal(1101111)→JAL; lui/auipc→UIMM (macro); else ILLEGAL. Also ILLEGAL for funct3 not in {000,010,110,111} on R/I-ALU, or funct3 not in {000,001} on branch.
- MEMADR: A10, B01, add; op[5]=0→MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc1, ResultSrc00; hold until mem_ready→MEMWB. MEMWB: ResultSrc01, RegWrite→FETCH.
- MEMWRITE: AdrSrc1, ResultSrc00, MemWrite=1 held until mem_ready→FETCH.
- EXECR: A10, B00, funct-decoded op→ALUWB. EXECI: A10, B01, funct-decoded op→ALUWB. ALUWB: ResultSrc00, RegWrite→FETCH.
- BRANCH: A10, B00, sub, ResultSrc00, PCWrite=zero^funct3[0] (beq/bne)→FETCH.
- JAL: A01, B10, add, ResultSrc00, PCWrite→ALUWB (rd=OldPC+4).
- ILLEGAL: illegal=1, no strobes→FETCH.
- Funct decode: 000 add (sub when R-type and funct7b5); 010 slt; 110 or; 111 and. Address/PC states force add; BRANCH forces sub.
- ImmSrc combinational from op: I for lw/I-ALU, S sw, B branch, J jal, U lui/auipc; 100 otherwise.
- Unlisted outputs in a state are 0.

## Timing
- Outputs Moore-decoded from state, except FETCH strobes and BRANCH PCWrite (gated by mem_ready/zero), and ImmSrc (from op).
- Latency with mem_ready always 1: lw 5, sw 4, R/I 4, branch 3, jal 4, lui/auipc 4, illegal 3 cycles.
- mem_ready ignored outside FETCH/MEMREAD/MEMWRITE.
- reset high at an edge: state←FETCH regardless of current state (including mid-stall); while reset high all strobes (PCWrite, IRWrite, MemWrite, RegWrite, illegal) forced 0; first fetch request the cycle after reset deasserts.

## Configuration
- UTYPE_EN defined: lui(0110111)→UIMM with A11, B01, add; auipc(0010111)→UIMM with A01, B01, add; UIMM→ALUWB.
- Undefined: UIMM state absent; lui/auipc decode to ILLEGAL; ALUSrcA code 11 never driven.

## Structure
- Package riscv_ctrl_pkg: state enum, opcode constants, ALUControl/ImmSrc/mux-select encodings.
- One sub-module: alu_decoder (aluop class, funct3, funct7b5, op[5] → ALUControl, funct-illegal flag).

## Test plan
- Reset asserted in MEMWRITE stall with mem_ready=0 → next cycle FETCH, MemWrite=0 during reset, IRWrite=0.
- lw (op 0000011), mem_ready low 2 FETCH cycles then 1 → FETCH×3, DECODE, MEMADR, MEMREAD, MEMWB with RegWrite=1, ResultSrc=01; ImmSrc=100.
- add/sub: op 0110011, funct3 000, funct7b5 1 → EXECR ALUControl=001, ALUWB RegWrite=1; funct3 100 → illegal pulse, no RegWrite.
- bne (funct3 001), zero=0 → BRANCH PCWrite=1; zero=1 → PCWrite=0; ImmSrc=010.
- jal → JAL PCWrite=1, A01/B10, then ALUWB RegWrite; ImmSrc=011.
- lui with UTYPE_EN → UIMM A11/B01, ALUWB RegWrite; without → illegal=1 for exactly one cycle, then FETCH.
